// File: rtl/dma_dev_port.sv
// Device-side endpoint of the DMA device handshake: takes a command from a local core,
// requests the transfer, paces it with dev_ack and streams words to/from a small buffer.
module dma_dev_port #(
  parameter int ADD_LEN   = 16,
  parameter int DATA_LEN  = 16,
  parameter int BUF_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic                 cmd_rd_wr,
  input  logic [ADD_LEN-1:0]   cmd_num_words,
  input  logic [ADD_LEN-1:0]   cmd_addr,
  input  logic                 ack_pause,
  input  logic                 buf_wr_en,
  input  logic [BUF_DEPTH-1:0] buf_addr,
  input  logic [DATA_LEN-1:0]  buf_wr_data,
  output logic [DATA_LEN-1:0]  buf_rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 rqst,
  output logic                 rd_wr,
  output logic [ADD_LEN-1:0]   num_words,
  output logic [ADD_LEN:0]     start_addr,
  output logic                 dev_ack,
  output logic [DATA_LEN-1:0]  dev_in,
  input  logic [DATA_LEN-1:0]  dev_out,
  input  logic                 dma_ack,
  input  logic                 end_flag
);

  localparam int                 WD_W         = $clog2(TIMEOUT) + 1;
  localparam logic [ADD_LEN-1:0] LP_BUF_WORDS = ADD_LEN'(2 ** BUF_DEPTH);
  localparam logic [WD_W-1:0]    LP_WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN, S_FIN} state_t;

  state_t              r_state;
  logic [DATA_LEN-1:0] r_mem [2**BUF_DEPTH];
  logic                r_rd_wr;
  logic [ADD_LEN-1:0]  r_num_words;
  logic [ADD_LEN:0]    r_start_addr;
  logic [ADD_LEN-1:0]  r_ptr;
  logic [WD_W-1:0]     r_wdog;
  logic                r_rqst;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                 w_in_xfer;
  logic                 w_room;
  logic                 w_take;
  logic [ADD_LEN-1:0]   w_ptr_next;
  logic                 w_timeout;
  logic [BUF_DEPTH-1:0] w_idx;

  assign w_in_xfer  = (r_state == S_XFER);
  assign w_room     = (r_ptr < r_num_words);
  assign w_take     = w_in_xfer & dma_ack & w_room;
  assign w_ptr_next = w_take ? r_ptr + 1'b1 : r_ptr;
  assign w_timeout  = (r_wdog == LP_WD_LAST);
  // Oversize commands are rejected up front, so the low pointer bits never wrap.
  assign w_idx      = r_ptr[BUF_DEPTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rd_wr      <= 1'b0;
      r_num_words  <= '0;
      r_start_addr <= '0;
      r_ptr        <= '0;
      r_wdog       <= '0;
      r_rqst       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_rqst  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_rd_wr      <= cmd_rd_wr;
            r_num_words  <= cmd_num_words;
            r_start_addr <= {1'b0, cmd_addr};
            if (cmd_num_words == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else if (cmd_num_words > LP_BUF_WORDS) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_rqst  <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          r_ptr   <= '0;
          r_wdog  <= '0;
          r_state <= S_XFER;
        end
        S_XFER: begin
          r_ptr  <= w_ptr_next;
          r_wdog <= r_wdog + 1'b1;
          // A word arriving with end_flag is counted before judging a short read.
          if (end_flag) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= r_rd_wr & (w_ptr_next != r_num_words);
          end else if (w_timeout) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end else if (w_ptr_next == r_num_words) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_wdog <= r_wdog + 1'b1;
          if (end_flag) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_error <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && buf_wr_en) begin
      r_mem[buf_addr] <= buf_wr_data;
    end else if (w_take && r_rd_wr) begin
      r_mem[w_idx] <= dev_out;
    end
  end

  assign buf_rd_data = r_mem[buf_addr];
  assign dev_in      = w_in_xfer ? r_mem[w_idx] : '0;
  assign dev_ack     = w_in_xfer & ~ack_pause & w_room;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign rqst        = r_rqst;
  assign rd_wr       = r_rd_wr;
  assign num_words   = r_num_words;
  assign start_addr  = r_start_addr;

endmodule
